// File: rtl/pipeline_stage_skid.sv
// pipeline_stage_skid: elastic pipeline register with a two-entry skid buffer and fully registered in_ready.
// Optional PIPE_STAGE_PERF_EN adds saturating stall_cnt / flush_cnt outputs.
module pipeline_stage_skid #(
  parameter int CTRL_W    = 10,
  parameter int PAYLOAD_W = 197,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CTRL_W-1:0]    in_ctrl,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [1:0]           occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
`endif
);
  logic main_v_q, main_v_d, skid_v_q, skid_v_d, rdy_q, rdy_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [PAYLOAD_W-1:0] main_pl_q, main_pl_d, skid_pl_q, skid_pl_d;
  logic [1:0] occ_q, occ_d;
  logic accept, fire;
  assign accept      = in_valid & rdy_q;
  assign fire        = main_v_q & out_ready;
  assign in_ready    = rdy_q;
  assign out_valid   = main_v_q;
  assign out_ctrl    = main_ctrl_q;
  assign out_payload = main_pl_q;
  assign occupancy   = occ_q;
  always_comb begin
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    main_ctrl_d = main_ctrl_q;
    skid_ctrl_d = skid_ctrl_q;
    main_pl_d   = main_pl_q;
    skid_pl_d   = skid_pl_q;
    if (flush) begin
      main_v_d    = 1'b0;
      skid_v_d    = 1'b0;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else if (skid_v_q) begin
      if (fire) begin
        main_ctrl_d = skid_ctrl_q;
        main_pl_d   = skid_pl_q;
        skid_v_d    = 1'b0;
        skid_ctrl_d = '0;
      end
    end else if (accept && (!main_v_q || fire)) begin
      main_v_d    = 1'b1;
      main_ctrl_d = in_ctrl;
      main_pl_d   = in_payload;
    end else if (accept) begin
      skid_v_d    = 1'b1;
      skid_ctrl_d = in_ctrl;
      skid_pl_d   = in_payload;
    end else if (fire) begin
      main_v_d    = 1'b0;
      main_ctrl_d = '0;
    end
    // in_ready is a flop so out_ready never reaches it combinationally
    rdy_d = !skid_v_d;
    occ_d = {skid_v_d, main_v_d & !skid_v_d};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      rdy_q       <= 1'b0;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
      main_pl_q   <= '0;
      skid_pl_q   <= '0;
      occ_q       <= '0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      rdy_q       <= rdy_d;
      main_ctrl_q <= main_ctrl_d;
      skid_ctrl_q <= skid_ctrl_d;
      main_pl_q   <= main_pl_d;
      skid_pl_q   <= skid_pl_d;
      occ_q       <= occ_d;
    end
  end
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  always_comb begin
    stall_d = stall_q + CNT_W'(main_v_q && !out_ready && stall_q != '1);
    flush_d = flush_q + CNT_W'(flush && main_v_q && flush_q != '1);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif
endmodule
